// File: rtl/drum_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : drum_pkg
//  Purpose  : Shared types and widths for the drum-machine step sequencer.
//  Revision : 1.0  initial release
// ============================================================================
package drum_pkg;

    localparam int TRACKS = 4;
    localparam int STEPS  = 8;
    localparam int STEP_W = 3;
    localparam int PAT_W  = 8;
    localparam int BPM_W  = 8;
    localparam int ACC_W  = 33;

    // Load/play sequence; LD_INS1..LD_INS4 encode the track index in bits [1:0].
    typedef enum logic [2:0] {
        LD_INS1 = 3'd0,
        LD_INS2 = 3'd1,
        LD_INS3 = 3'd2,
        LD_INS4 = 3'd3,
        LD_BPM  = 3'd4,
        PLAY    = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/step_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : step_sequencer_if
//  Purpose  : Board-side controls and voice/display outputs of the sequencer.
//  Revision : 1.0  initial release
// ============================================================================
interface step_sequencer_if;
    import drum_pkg::*;

    logic                go;
    logic [PAT_W-1:0]    sel;
    logic [TRACKS-1:0]   ld_ins;
    logic                ld_bpm;
    logic                play;
    logic [STEP_W-1:0]   step;
    logic                step_tick;
    logic [TRACKS-1:0]   hit;
    logic [PAT_W-1:0]    ins0;
    logic [PAT_W-1:0]    ins1;
    logic [PAT_W-1:0]    ins2;
    logic [PAT_W-1:0]    ins3;
    logic [BPM_W-1:0]    bpm;

    // Board / test side: drives the switches and the go key.
    modport master (
        output go, sel,
        input  ld_ins, ld_bpm, play, step, step_tick, hit,
        input  ins0, ins1, ins2, ins3, bpm
    );

    // Sequencer side.
    modport slave (
        input  go, sel,
        output ld_ins, ld_bpm, play, step, step_tick, hit,
        output ins0, ins1, ins2, ins3, bpm
    );

endinterface
`default_nettype wire

// File: rtl/bpm_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module   : bpm_tick_gen
//  Purpose  : Fractional tempo divider. Adds bpm each enabled cycle and
//             signals a tick whenever the sum reaches CLK_HZ*60, so the mean
//             tick period is exactly CLK_HZ*60/bpm cycles.
//  Revision : 1.0  initial release
// ============================================================================
module bpm_tick_gen #(
    parameter int CLK_HZ = 50_000_000
) (
    input  wire                        clk,
    input  wire                        reset,
    input  wire                        en,
    input  wire                        clr,
    input  wire [drum_pkg::BPM_W-1:0]  bpm,
    output logic                       tick
);
    import drum_pkg::*;

    // 60*CLK_HZ exceeds 32 bits for realistic clocks, so build it at full width.
    localparam logic [ACC_W-1:0] LIMIT = ACC_W'(CLK_HZ) * ACC_W'(60);

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W-1:0] sum;

    assign sum  = acc_q + ACC_W'(bpm);
    assign tick = en && !clr && (sum >= LIMIT);

    // Next accumulator value: clear, wrap on tick, or plain add.
    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = tick ? (sum - LIMIT) : sum;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/step_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : step_sequencer
//  Purpose  : Four-track, eight-step drum sequencer controller: load FSM,
//             pattern/BPM storage, tempo tick, step cursor and hit triggers.
//  Revision : 1.0  initial release
// ============================================================================
module step_sequencer #(
    parameter int CLK_HZ = 50_000_000,
    parameter int TRACKS = 4,
    parameter int STEPS  = 8
) (
    input  wire              clk,
    input  wire              reset,
    step_sequencer_if.slave  bus
);
    import drum_pkg::*;

    state_t               state_q, state_d;
    logic                 go_q;
    logic                 go_rise;
    logic                 tick;
    logic [PAT_W-1:0]     ins_q [TRACKS];
    logic [PAT_W-1:0]     ins_d [TRACKS];
    logic [BPM_W-1:0]     bpm_q, bpm_d;
    logic [STEP_W-1:0]    step_q, step_d, step_nxt;
    logic                 step_tick_q, step_tick_d;
    logic [TRACKS-1:0]    hit_q, hit_d;
    logic [TRACKS-1:0]    ld_ins_q, ld_ins_d;
    logic                 ld_bpm_q, play_q;

    assign go_rise = bus.go & ~go_q;

    // The accumulator only runs in PLAY; a stop clears it on the same edge.
    bpm_tick_gen #(
        .CLK_HZ (CLK_HZ)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .en    (state_q == PLAY),
        .clr   ((state_q != PLAY) || go_rise),
        .bpm   (bpm_q),
        .tick  (tick)
    );

    // Next state, captured data, step cursor and trigger pulses.
    always_comb begin
        state_d     = state_q;
        ins_d       = ins_q;
        bpm_d       = bpm_q;
        step_d      = step_q;
        step_tick_d = 1'b0;
        hit_d       = '0;
        step_nxt    = step_q + 3'd1;
        case (state_q)
            LD_INS1, LD_INS2, LD_INS3, LD_INS4: begin
                if (go_rise) begin
                    ins_d[state_q[1:0]] = bus.sel;
                    state_d             = state_t'(state_q + 3'd1);
                end
            end
            LD_BPM: begin
                if (go_rise) begin
                    bpm_d       = bus.sel;
                    state_d     = PLAY;
                    step_d      = '0;
                    step_tick_d = 1'b1;
                    for (int t = 0; t < TRACKS; t++) begin
                        hit_d[t] = ins_q[t][PAT_W-1];
                    end
                end
            end
            PLAY: begin
                // A stop request takes priority over a coincident tick.
                if (go_rise) begin
                    state_d = LD_INS1;
                    step_d  = '0;
                end else if (tick) begin
                    step_d      = step_nxt;
                    step_tick_d = 1'b1;
                    for (int t = 0; t < TRACKS; t++) begin
                        hit_d[t] = ins_q[t][3'(STEPS - 1) - step_nxt];
                    end
                end
            end
            default: state_d = LD_INS1;
        endcase

        ld_ins_d = '0;
        if (state_d inside {LD_INS1, LD_INS2, LD_INS3, LD_INS4}) begin
            ld_ins_d = TRACKS'(1) << state_d[1:0];
        end
    end

    // State, data and registered output flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= LD_INS1;
            go_q        <= 1'b0;
            bpm_q       <= '0;
            step_q      <= '0;
            step_tick_q <= 1'b0;
            hit_q       <= '0;
            ld_ins_q    <= TRACKS'(1);
            ld_bpm_q    <= 1'b0;
            play_q      <= 1'b0;
            for (int t = 0; t < TRACKS; t++) begin
                ins_q[t] <= '0;
            end
        end else begin
            state_q     <= state_d;
            go_q        <= bus.go;
            bpm_q       <= bpm_d;
            step_q      <= step_d;
            step_tick_q <= step_tick_d;
            hit_q       <= hit_d;
            ld_ins_q    <= ld_ins_d;
            ld_bpm_q    <= (state_d == LD_BPM);
            play_q      <= (state_d == PLAY);
            ins_q       <= ins_d;
        end
    end

    assign bus.ld_ins    = ld_ins_q;
    assign bus.ld_bpm    = ld_bpm_q;
    assign bus.play      = play_q;
    assign bus.step      = step_q;
    assign bus.step_tick = step_tick_q;
    assign bus.hit       = hit_q;
    assign bus.ins0      = ins_q[0];
    assign bus.ins1      = ins_q[1];
    assign bus.ins2      = ins_q[2];
    assign bus.ins3      = ins_q[3];
    assign bus.bpm       = bpm_q;

endmodule
`default_nettype wire

// File: tb/tb_step_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_step_sequencer
//  Purpose  : Self-checking bench for step_sequencer at CLK_HZ=60.
//  Revision : 1.0  initial release
// ============================================================================
module tb_step_sequencer;

    localparam int  LIMIT = 3600;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    step_sequencer_if bus();

    step_sequencer #(
        .CLK_HZ (60),
        .TRACKS (4),
        .STEPS  (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Tempo is modelled as "ticks so far = floor(n*bpm/LIMIT)" where n is the
    // number of PLAY cycles elapsed since the downbeat.
    int          m_mode;       // 0..3 load track, 4 load bpm, 5 play
    logic [7:0]  m_ins [4];
    logic [7:0]  m_bpm;
    logic        m_go_q;
    longint      m_n, m_ticks, m_nt;
    logic [2:0]  m_step;
    logic        m_tick;
    logic [3:0]  m_hit;
    bit          m_rise;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_mode = 0; m_bpm = 0; m_go_q = 0; m_n = 0; m_ticks = 0;
            m_step = 0; m_tick = 0; m_hit = 0;
            for (int t = 0; t < 4; t++) m_ins[t] = 0;
        end else begin
            m_rise = bus.go && !m_go_q;
            m_go_q = bus.go;
            m_tick = 0;
            m_hit  = 0;
            if (m_mode < 4) begin
                if (m_rise) begin
                    m_ins[m_mode] = bus.sel;
                    m_mode++;
                end
            end else if (m_mode == 4) begin
                if (m_rise) begin
                    m_bpm = bus.sel; m_mode = 5; m_n = 0; m_ticks = 0;
                    m_step = 0; m_tick = 1;
                    for (int t = 0; t < 4; t++) m_hit[t] = m_ins[t][7];
                end
            end else begin
                if (m_rise) begin
                    m_mode = 0; m_step = 0;
                end else begin
                    m_n++;
                    m_nt = (m_n * longint'(m_bpm)) / LIMIT;
                    if (m_nt != m_ticks) begin
                        m_ticks = m_nt;
                        m_step  = 3'(m_ticks % 8);
                        m_tick  = 1;
                        for (int t = 0; t < 4; t++) m_hit[t] = (m_ins[t] >> (7 - m_step)) & 8'd1;
                    end
                end
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        chk("m_ld_ins", bus.ld_ins, (m_mode < 4) ? (4'b1 << m_mode) : 4'b0);
        chk("m_ld_bpm", bus.ld_bpm, m_mode == 4);
        chk("m_play", bus.play, m_mode == 5);
        chk("m_step", bus.step, m_step);
        chk("m_step_tick", bus.step_tick, m_tick);
        chk("m_hit", bus.hit, m_hit);
        chk("m_ins0", bus.ins0, m_ins[0]);
        chk("m_ins1", bus.ins1, m_ins[1]);
        chk("m_ins2", bus.ins2, m_ins[2]);
        chk("m_ins3", bus.ins3, m_ins[3]);
        chk("m_bpm", bus.bpm, m_bpm);
    end

    // ---------------- directed stimulus ----------------
    task automatic pulse(input logic [7:0] v);
        bus.sel = v;
        bus.go  = 1'b1;
        @(negedge clk);
        bus.go  = 1'b0;
    endtask

    task automatic load(input logic [7:0] b);
        pulse(8'h88); @(negedge clk);
        pulse(8'h22); @(negedge clk);
        pulse(8'hFF); @(negedge clk);
        pulse(8'h01); @(negedge clk);
        pulse(b);
    endtask

    task automatic wait_tick(input int budget, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bus.step_tick && cyc < budget);
        if (!bus.step_tick) begin
            total++; bad++;
            $display("FAIL tick_timeout: got no step_tick within %0d cycles", budget);
        end
    endtask

    logic [3:0] hit_tab [8];
    int cyc, sum, cnt;

    initial begin
        hit_tab = '{4'b0101, 4'b0100, 4'b0110, 4'b0100,
                    4'b0101, 4'b0100, 4'b0110, 4'b1100};
        bus.go = 1'b0; bus.sel = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_ld_ins", bus.ld_ins, 4'b0001);
        chk("rst_play", bus.play, 0);
        chk("rst_step", bus.step, 0);
        chk("rst_hit", bus.hit, 0);
        chk("rst_ins0", bus.ins0, 0);
        chk("rst_bpm", bus.bpm, 0);
        reset = 1'b1;
        @(negedge clk);

        // go held high: exactly one advance.
        bus.sel = 8'h88; bus.go = 1'b1;
        repeat (100) @(negedge clk);
        chk("hold_ld_ins", bus.ld_ins, 4'b0010);
        chk("hold_ins0", bus.ins0, 8'h88);
        bus.go = 1'b0;
        @(negedge clk);
        pulse(8'h22); @(negedge clk);
        pulse(8'hFF); @(negedge clk);
        pulse(8'h01); @(negedge clk);
        chk("ld_bpm_state", bus.ld_bpm, 1);
        pulse(8'd120);

        // Downbeat cycle.
        chk("entry_play", bus.play, 1);
        chk("entry_hit", bus.hit, 4'b0101);
        chk("entry_step", bus.step, 0);
        chk("entry_tick", bus.step_tick, 1);
        chk("entry_ins1", bus.ins1, 8'h22);
        chk("entry_ins2", bus.ins2, 8'hFF);
        chk("entry_ins3", bus.ins3, 8'h01);
        chk("entry_bpm", bus.bpm, 8'd120);

        // bpm=120 -> one step every 30 cycles, full bar and wrap.
        for (int s = 1; s <= 8; s++) begin
            wait_tick(40, cyc);
            chk("t120_interval", cyc, 30);
            chk("t120_step", bus.step, s % 8);
            chk("t120_hit", bus.hit, hit_tab[s % 8]);
        end

        // Stop on the very edge of the next tick.
        repeat (29) @(negedge clk);
        bus.go = 1'b1;
        @(negedge clk);
        bus.go = 1'b0;
        chk("stop_hit", bus.hit, 0);
        chk("stop_step", bus.step, 0);
        chk("stop_tick", bus.step_tick, 0);
        chk("stop_ld_ins", bus.ld_ins, 4'b0001);
        chk("stop_play", bus.play, 0);
        chk("stop_ins0", bus.ins0, 8'h88);
        chk("stop_ins3", bus.ins3, 8'h01);
        chk("stop_bpm", bus.bpm, 8'd120);
        @(negedge clk);

        // bpm=7: intervals of 515/514 summing to one LIMIT over 7 ticks.
        load(8'd7);
        sum = 0;
        for (int i = 0; i < 7; i++) begin
            wait_tick(600, cyc);
            if (i == 0) chk("t7_first", cyc, 515);
            chk("t7_interval_ok", (cyc == 514 || cyc == 515), 1);
            sum += cyc;
        end
        chk("t7_sum", sum, LIMIT);
        chk("t7_step", bus.step, 7);

        // Asynchronous reset mid-PLAY.
        repeat (5) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("arst_play", bus.play, 0);
        chk("arst_ld_ins", bus.ld_ins, 4'b0001);
        chk("arst_step", bus.step, 0);
        chk("arst_hit", bus.hit, 0);
        chk("arst_ins0", bus.ins0, 0);
        chk("arst_bpm", bus.bpm, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // bpm=0: one downbeat, then silence.
        load(8'd0);
        chk("b0_entry_tick", bus.step_tick, 1);
        chk("b0_entry_hit", bus.hit, 4'b0101);
        cnt = 0;
        repeat (300) begin
            @(negedge clk);
            if (bus.step_tick) cnt++;
        end
        chk("b0_ticks", cnt, 0);
        chk("b0_step", bus.step, 0);
        chk("b0_play", bus.play, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
